// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-stream to UART TX line serializer.
// Frames are 8N1, LSB first, each bit held for DIV clock cycles. A byte is
// taken on a rising edge where vld_tx and rdy_tx are both high.
// Optional macro UART_TX_PARITY_EN inserts an even parity bit between the
// last data bit and the stop bit (8E1, 11*DIV-cycle frames).
module uart_tx_serializer #(
    parameter int unsigned DIV   = 868,
    parameter int unsigned CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d_tx,
    input  logic       vld_tx,
    output logic       rdy_tx,
    output logic       txd,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 32'd1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             rdy_q, rdy_d;
    logic             par_q, par_d;

    logic bit_end_s;
    logic accept_s;
    logic after_data_s;

    assign bit_end_s = (cnt_q == CNT_LAST);
    assign accept_s  = vld_tx & rdy_q;

    // Level driven after the last data bit: parity when enabled, else stop.
`ifdef UART_TX_PARITY_EN
    assign after_data_s = par_q;
`else
    assign after_data_s = 1'b1;
`endif

    // State register and all datapath flops, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
            rdy_q   <= 1'b1;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            rdy_q   <= rdy_d;
            par_q   <= par_d;
        end
    end

    // Next-state logic: advance one frame phase at each bit boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) state_d = S_START;
                else          state_d = S_IDLE;
            end
            S_START: begin
                if (bit_end_s) state_d = S_DATA;
                else           state_d = S_START;
            end
            S_DATA: begin
                if (bit_end_s && (idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end_s) state_d = S_STOP;
                else           state_d = S_PARITY;
            end
`endif
            S_STOP: begin
                if (bit_end_s) state_d = S_IDLE;
                else           state_d = S_STOP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath logic: next line level, flow control, counter, shifter.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        rdy_d   = rdy_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = 3'd0;
                if (accept_s) begin
                    shift_d = d_tx;
                    par_d   = ^d_tx;
                    txd_d   = 1'b0;
                    rdy_d   = 1'b0;
                end else begin
                    txd_d = 1'b1;
                    rdy_d = 1'b1;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    txd_d = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) txd_d = after_data_s;
                    else               txd_d = shift_q[1];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    txd_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    txd_d = 1'b1;
                    rdy_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
                idx_d = 3'd0;
                txd_d = 1'b1;
                rdy_d = 1'b1;
            end
        endcase
    end

    assign txd    = txd_q;
    assign rdy_tx = rdy_q;
    assign busy   = ~rdy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer with DIV=4.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_serializer;

    localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] PAT55 = 11'b100_1010_1010;
`else
    localparam int NB = 10;
    localparam logic [10:0] PAT55 = 11'b010_1010_1010;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d_tx;
    logic       vld_tx;
    logic       rdy_tx;
    logic       txd;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_tx_serializer #(.DIV(DIV), .CNT_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .d_tx   (d_tx),
        .vld_tx (vld_tx),
        .rdy_tx (rdy_tx),
        .txd    (txd),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Line level of frame bit k for byte b: start, 8 data LSB first, [parity], stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) begin
            return 1'b0;
        end else if (k <= 8) begin
            return b[k-1];
        end
`ifdef UART_TX_PARITY_EN
        else if (k == 9) begin
            return ^b;
        end
`endif
        else begin
            return 1'b1;
        end
    endfunction

    // Model: a frame is "in flight" for NB*DIV cycles after each accepting edge.
    logic       m_started = 1'b0;
    logic       m_act = 1'b0;
    int         m_off = 0;
    logic [7:0] m_byte = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            m_act     = 1'b0;
            m_started = 1'b1;
        end else if (m_started) begin
            if (m_act) begin
                m_off++;
                if (m_off == NB * DIV) m_act = 1'b0;
            end else if (vld_tx) begin
                m_act  = 1'b1;
                m_off  = 0;
                m_byte = d_tx;
            end
        end
    end

    // Compare DUT outputs with the model on every cycle after reset is seen.
    always @(negedge clk) begin
        if (m_started) begin
            chk("model_txd", txd, m_act ? frame_bit(m_byte, m_off / DIV) : 1'b1);
            chk("model_rdy", rdy_tx, !m_act);
            chk("model_busy", busy, m_act);
        end
    end

    // Line decoder: recovers bytes from txd by sampling mid-bit.
    logic       dec_on = 1'b0;
    int         dec_t = 0;
    logic [7:0] dec_b = 8'h00;
    logic [7:0] dec_q[$];
    logic       dec_par_q[$];

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            dec_on = 1'b0;
        end else if (!dec_on) begin
            if (txd === 1'b0) begin
                dec_on = 1'b1;
                dec_t  = 0;
            end
        end else begin
            dec_t++;
            for (int j = 1; j <= 8; j++)
                if (dec_t == j * DIV + DIV / 2) dec_b[j-1] = txd;
            if (NB == 11 && dec_t == 9 * DIV + DIV / 2) dec_par_q.push_back(txd);
            if (dec_t == (NB - 1) * DIV + DIV / 2) begin
                chk("stop_bit", txd, 1'b1);
                dec_q.push_back(dec_b);
                dec_on = 1'b0;
            end
        end
    end

    // Offer one byte for a single cycle and count cycles with rdy_tx low.
    task automatic send_byte(input logic [7:0] b, output int low);
        vld_tx = 1'b1;
        d_tx   = b;
        @(negedge clk);
        vld_tx = 1'b0;
        d_tx   = 8'h00;
        low    = 0;
        while (!rdy_tx && low < 200) begin
            low++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int low;
        int n;
        rst    = 1'b1;
        vld_tx = 1'b1;
        d_tx   = 8'h5A;
        // Reset with vld_tx held high: nothing is sent.
        @(negedge clk);
        chk("rst_txd", txd, 1'b1);
        chk("rst_rdy", rdy_tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        vld_tx = 1'b0;
        repeat (3) @(negedge clk);
        chk_int("rst_no_frame", dec_q.size(), 0);
        chk("rst_idle_txd", txd, 1'b1);

        // Single byte 0x55 against the literal line pattern.
        vld_tx = 1'b1;
        d_tx   = 8'h55;
        @(negedge clk);
        vld_tx = 1'b0;
        for (int i = 0; i < NB * DIV; i++) begin
            chk("b55_txd", txd, PAT55[i / DIV]);
            chk("b55_rdy_low", rdy_tx, 1'b0);
            @(negedge clk);
        end
        chk("b55_rdy_back", rdy_tx, 1'b1);
        chk_int("b55_count", dec_q.size(), 1);
        if (dec_q.size() == 1) chk_int("b55_byte", int'(dec_q[0]), 32'h55);
        dec_q.delete();
        dec_par_q.delete();
        repeat (2) @(negedge clk);

        // Back-to-back 0x41 then 0x0D with vld_tx held high.
        vld_tx = 1'b1;
        d_tx   = 8'h41;
        @(negedge clk);
        d_tx = 8'h0D;
        n = 0;
        while (!rdy_tx && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk_int("b2b_gap", n, NB * DIV);
        @(negedge clk);
        vld_tx = 1'b0;
        chk("b2b_start", txd, 1'b0);
        chk("b2b_rdy", rdy_tx, 1'b0);
        n = 0;
        while (!rdy_tx && n < 200) begin
            n++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk_int("b2b_count", dec_q.size(), 2);
        if (dec_q.size() == 2) begin
            chk_int("b2b_byte0", int'(dec_q[0]), 32'h41);
            chk_int("b2b_byte1", int'(dec_q[1]), 32'h0D);
        end
        dec_q.delete();
        dec_par_q.delete();

        // vld_tx with 0xFF while busy sending 0x00 is ignored.
        vld_tx = 1'b1;
        d_tx   = 8'h00;
        @(negedge clk);
        d_tx = 8'hFF;
        repeat (20) @(negedge clk);
        vld_tx = 1'b0;
        d_tx   = 8'h00;
        n = 0;
        while (!rdy_tx && n < 200) begin
            n++;
            @(negedge clk);
        end
        repeat (NB * DIV) @(negedge clk);
        chk_int("ign_count", dec_q.size(), 1);
        if (dec_q.size() == 1) chk_int("ign_byte", int'(dec_q[0]), 32'h00);
        dec_q.delete();
        dec_par_q.delete();

        // Reset mid-frame at cycle 15 of a 0x00 frame.
        vld_tx = 1'b1;
        d_tx   = 8'h00;
        @(negedge clk);
        vld_tx = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_txd", txd, 1'b1);
        chk("mid_rst_rdy", rdy_tx, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        dec_q.delete();
        dec_par_q.delete();
        send_byte(8'hA5, low);
        chk_int("a5_frame_len", low, NB * DIV);
        repeat (2) @(negedge clk);
        chk_int("a5_count", dec_q.size(), 1);
        if (dec_q.size() == 1) chk_int("a5_byte", int'(dec_q[0]), 32'hA5);
        dec_q.delete();
        dec_par_q.delete();

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0, 44-cycle frames.
        send_byte(8'h07, low);
        chk_int("p07_frame_len", low, 44);
        send_byte(8'h03, low);
        chk_int("p03_frame_len", low, 44);
        repeat (2) @(negedge clk);
        chk_int("par_count", dec_par_q.size(), 2);
        if (dec_par_q.size() == 2) begin
            chk("p07_parity", dec_par_q[0], 1'b1);
            chk("p03_parity", dec_par_q[1], 1'b0);
        end
`else
        send_byte(8'h07, low);
        chk_int("n07_frame_len", low, 40);
        repeat (2) @(negedge clk);
        chk_int("n07_count", dec_q.size(), 1);
        if (dec_q.size() == 1) chk_int("n07_byte", int'(dec_q[0]), 32'h07);
`endif

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Downstream stage of the console print engine.
- Consumes the byte stream on d_tx/vld_tx and returns rdy_tx flow control.
- Serialises each byte onto the board UART TX pin as 8N1, LSB first, with a fixed baud divider.
- The print engine's character sequencing (hex digits, '_', CR/LF) depends only on the rdy_tx/vld_tx handshake defined here.

Parameters:
- DIV, 868, clock cycles per bit period (100 MHz / 115200). Legal range 2..65535.
- CNT_W, 16, width of the baud counter. Must satisfy 2^CNT_W > DIV.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- d_tx  input  8  byte to send; sampled only on a handshake cycle
- vld_tx  input  1  upstream offers d_tx
- rdy_tx  output  1  serializer idle and able to accept a byte
- txd  output  1  serial line, idle high
- busy  output  1  frame in progress (equal to ~rdy_tx)

Behaviour:
- Reset: state IDLE, txd=1, rdy_tx=1, busy=0, baud counter=0, bit index=0, shift register=0.
- Reset sampled high mid-frame aborts the frame. txd=1 and rdy_tx=1 from the next edge. No partial-frame completion.
- Handshake:
  - A byte is accepted on a rising edge where vld_tx=1 and rdy_tx=1.
  - d_tx is latched into the shift register on that edge.
  - rdy_tx is registered and drops on the same edge.
  - vld_tx while rdy_tx=0 is ignored. No data is captured and no error is flagged.
  - d_tx may change freely outside handshake cycles.
- States: IDLE -> START -> DATA -> STOP -> IDLE. txd is a registered output.
  - IDLE: txd=1, rdy_tx=1. Handshake -> START; txd=0 from the accepting edge.
  - START: txd=0 for exactly DIV cycles, then -> DATA with bit index 0.
  - DATA: txd=shift[0] for DIV cycles per bit, then shift right and increment the index. After bit index 7 completes -> STOP.
  - STOP: txd=1 for DIV cycles. On the last cycle of STOP, rdy_tx is set to 1 and the state returns to IDLE.
- Baud counter:
  - Counts 0..DIV-1 within each bit and wraps to 0 on each bit boundary.
  - It is cleared on handshake, so every bit lasts exactly DIV cycles.
- Frame length: 10*DIV cycles from the accepting edge to rdy_tx=1.
- Back-to-back transfers: if vld_tx=1 on the first cycle rdy_tx is high, the next START begins immediately. Throughput is one byte per 10*DIV+1 cycles, and the line never shows a glitch between frames.
- Output relations: busy is always ~rdy_tx. txd never goes X after reset.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even parity bit (XOR of the 8 data bits) for DIV cycles.
  - Frame becomes 11*DIV cycles (8E1).
- Undefined: no PARITY state, 8N1, 10*DIV-cycle frames. Logic and ports are otherwise identical.

Test Plan:
- Reset with DIV=4: hold rst=1 for 3 cycles -> txd=1, rdy_tx=1, busy=0 after the first reset edge. Assert vld_tx during reset -> nothing is sent.
- Single byte 0x55, DIV=4: pulse vld_tx one cycle -> txd sequence 0,1,0,1,0,1,0,1,0,1 with each level held exactly 4 cycles; rdy_tx low for 40 cycles then high.
- Back-to-back 0x41 then 0x0D with vld_tx held high -> two frames, second start bit beginning 1 cycle after rdy_tx rises; decoded bytes 0x41, 0x0D; no extra low pulses.
- vld_tx asserted with d_tx=0xFF while busy from sending 0x00 -> 0xFF is not captured; the line shows only the 0x00 frame (start plus 8 zeros, then stop).
- Reset mid-frame: rst=1 at cycle 15 of a 0x00 frame (DIV=4) -> txd=1 and rdy_tx=1 on the next edge; a new byte 0xA5 then sends correctly.
- With UART_TX_PARITY_EN, DIV=4: send 0x07 -> parity bit 1 after data; frame 44 cycles. Send 0x03 -> parity bit 0.
